uart_rx_os16: RTL and testbench



---
 rtl/uart_rx_os16_if.sv | 28 ++
 rtl/uart_rx_os16.sv | 214 +++++++++++++++++++++
 tb/tb_uart_rx_os16.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_os16_if.sv
// Core-side bus of the oversampling UART receiver:
// received byte, valid/ack handshake and status flags.
interface uart_rx_os16_if;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ack;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;

    modport master (
        output data_out,
        output data_valid,
        output frame_err,
        output overrun,
        output rx_busy,
        input  data_ack
    );

    modport slave (
        input  data_out,
        input  data_valid,
        input  frame_err,
        input  overrun,
        input  rx_busy,
        output data_ack
    );
endinterface

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver with 16x oversampling, 3-sample majority vote,
// false-start rejection, framing/overrun flags and valid/ack output.
module uart_rx_os16 #(
    parameter int OS_DIV_0 = 326,
    parameter int OS_DIV_1 = 163,
    parameter int OS_DIV_2 = 54,
    parameter int OS_DIV_3 = 27
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [1:0]        i_baud_fix,
    input  logic              i_rx_pin,
    uart_rx_os16_if.master    bus
);

    localparam int CW = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [1:0]    r_sync;
    logic          r_rxs_prev;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_div_m1;
    logic [CW-1:0] w_div_m1_sel;
    logic [3:0]    r_os;
    logic [2:0]    r_bit_idx;
    logic          r_s7;
    logic          r_s8;
    logic [7:0]    r_shreg;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_ferr;
    logic          r_ovr;
    logic          r_busy;

    logic w_rxs;
    logic w_fall;
    logic w_tick;
    logic w_vote;
    logic w_os15;
    logic w_maj;
    logic w_start;
    logic w_capture;
    logic w_ferr;
    logic w_ack;

    assign w_rxs  = r_sync[1];
    assign w_fall = r_rxs_prev & ~w_rxs;
    assign w_tick = (r_state != S_IDLE) && (r_cnt == r_div_m1);
    assign w_vote = w_tick && (r_os == 4'd9);
    assign w_os15 = w_tick && (r_os == 4'd15);
    assign w_maj  = (r_s7 & r_s8) | (r_s7 & w_rxs) | (r_s8 & w_rxs);
    assign w_ack  = bus.data_ack & r_valid;

    always_comb begin
        w_div_m1_sel = CW'(OS_DIV_3 - 1);
        unique case (i_baud_fix)
            2'd0: w_div_m1_sel = CW'(OS_DIV_0 - 1);
            2'd1: w_div_m1_sel = CW'(OS_DIV_1 - 1);
            2'd2: w_div_m1_sel = CW'(OS_DIV_2 - 1);
            2'd3: w_div_m1_sel = CW'(OS_DIV_3 - 1);
            default: w_div_m1_sel = CW'(OS_DIV_3 - 1);
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_capture = 1'b0;
        w_ferr    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_next  = S_START;
                    w_start = 1'b1;
                end
            end
            S_START: begin
                if (w_vote && w_maj) begin
                    w_next = S_IDLE;
                end else if (w_os15) begin
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_os15 && (r_bit_idx == 3'd7)) begin
                    w_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_vote) begin
                    if (w_maj) begin
                        w_capture = 1'b1;
                        w_next    = S_IDLE;
                    end else begin
                        w_ferr = 1'b1;
                        w_next = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (w_rxs) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync     <= 2'b11;
            r_rxs_prev <= 1'b1;
        end else begin
            r_sync     <= {r_sync[0], i_rx_pin};
            r_rxs_prev <= w_rxs;
        end
    end

    // Divisor and oversample counters restart on every start edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_div_m1 <= CW'(OS_DIV_3 - 1);
            r_os     <= 4'd0;
        end else if (w_start) begin
            r_cnt    <= '0;
            r_div_m1 <= w_div_m1_sel;
            r_os     <= 4'd0;
        end else if (r_state != S_IDLE) begin
            if (w_tick) begin
                r_cnt <= '0;
                r_os  <= r_os + 4'd1;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s7      <= 1'b1;
            r_s8      <= 1'b1;
            r_shreg   <= 8'h00;
            r_bit_idx <= 3'd0;
        end else begin
            if (w_tick && (r_os == 4'd7)) begin
                r_s7 <= w_rxs;
            end
            if (w_tick && (r_os == 4'd8)) begin
                r_s8 <= w_rxs;
            end
            if (w_start) begin
                r_bit_idx <= 3'd0;
            end else if ((r_state == S_DATA) && w_os15) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if ((r_state == S_DATA) && w_vote) begin
                r_shreg <= {w_maj, r_shreg[7:1]};
            end
        end
    end

    // A capture in the same cycle as an ack keeps valid high; the
    // acked byte was consumed, so that case is not an overrun.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
            r_ferr  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_ferr <= w_ferr;
            r_busy <= (w_next != S_IDLE);
            if (w_capture) begin
                r_data  <= r_shreg;
                r_valid <= 1'b1;
                if (r_valid && !bus.data_ack) begin
                    r_ovr <= 1'b1;
                end else if (w_ack) begin
                    r_ovr <= 1'b0;
                end
            end else if (w_ack) begin
                r_valid <= 1'b0;
                r_ovr   <= 1'b0;
            end
        end
    end

    assign bus.data_out   = r_data;
    assign bus.data_valid = r_valid;
    assign bus.frame_err  = r_ferr;
    assign bus.overrun    = r_ovr;
    assign bus.rx_busy    = r_busy;

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16: frames are driven bit by bit and
// expected bytes flow through a scoreboard queue.
module tb_uart_rx_os16;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] baud_fix;
    logic       rx;

    uart_rx_os16_if u_bus ();

    uart_rx_os16 u_dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_baud_fix (baud_fix),
        .i_rx_pin   (rx),
        .bus        (u_bus.master)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int fe_hi   = 0;
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        if (u_bus.frame_err === 1'b1) fe_hi <= fe_hi + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // nbit >= 0 puts a one-tick low pulse around os_cnt=8 of that bit.
    task automatic send_frame(input logic [7:0] b, input int div,
                              input bit stopv, input int nbit,
                              input bit chg);
        int bp;
        bp = 16 * div;
        rx = 1'b0;
        idle(bp);
        if (chg) baud_fix = 2'd0;
        for (int i = 0; i < 8; i++) begin
            if (i == nbit) begin
                rx = 1'b1;
                idle(8 * div + div / 2);
                rx = 1'b0;
                idle(div);
                rx = 1'b1;
                idle(bp - (8 * div + div / 2) - div);
            end else begin
                rx = b[i];
                idle(bp);
            end
        end
        rx = stopv;
        idle(bp);
    endtask

    task automatic check_rx(input string tag);
        int n;
        logic [7:0] e;
        n = 0;
        while (u_bus.data_valid !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, {31'd0, u_bus.data_valid}, 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_data"}, {24'd0, u_bus.data_out}, {24'd0, e});
        end
        chk({tag, "_ferr"}, {31'd0, u_bus.frame_err}, 32'd0);
    endtask

    task automatic do_ack(input string tag);
        u_bus.data_ack = 1'b1;
        @(negedge clk);
        u_bus.data_ack = 1'b0;
        chk({tag, "_ack_valid"}, {31'd0, u_bus.data_valid}, 32'd0);
        chk({tag, "_ack_ovr"}, {31'd0, u_bus.overrun}, 32'd0);
    endtask

    initial begin
        int fe0;
        rst = 1'b1;
        rx = 1'b1;
        baud_fix = 2'd3;
        u_bus.data_ack = 1'b0;
        idle(3);
        chk("reset_outs", {19'd0, u_bus.data_out, u_bus.data_valid,
            u_bus.frame_err, u_bus.overrun, u_bus.rx_busy}, 32'd0);
        rst = 1'b0;
        idle(20);

        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 27, 1'b1, -1, 1'b0);
        check_rx("a5");
        chk("a5_ovr", {31'd0, u_bus.overrun}, 32'd0);
        do_ack("a5");

        baud_fix = 2'd2;
        idle(30);
        exp_q.push_back(8'h00);
        send_frame(8'h00, 54, 1'b1, -1, 1'b0);
        chk("b2b_busy_gap", {31'd0, u_bus.rx_busy}, 32'd0);
        check_rx("b2b_00");
        do_ack("b2b_00");
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 54, 1'b1, -1, 1'b0);
        check_rx("b2b_ff");
        do_ack("b2b_ff");

        baud_fix = 2'd3;
        idle(30);
        fe0 = fe_hi;
        rx = 1'b0;
        idle(50);
        chk("glitch_busy", {31'd0, u_bus.rx_busy}, 32'd1);
        idle(58);
        rx = 1'b1;
        idle(20 * 27);
        chk("glitch_idle", {31'd0, u_bus.rx_busy}, 32'd0);
        chk("glitch_valid", {31'd0, u_bus.data_valid}, 32'd0);
        chk("glitch_ferr", fe_hi - fe0, 32'd0);

        send_frame(8'h3C, 27, 1'b0, -1, 1'b0);
        idle(3 * 4320);
        chk("brk_ferr_once", fe_hi - fe0, 32'd1);
        chk("brk_valid", {31'd0, u_bus.data_valid}, 32'd0);
        chk("brk_busy", {31'd0, u_bus.rx_busy}, 32'd1);
        rx = 1'b1;
        idle(10);
        chk("brk_release", {31'd0, u_bus.rx_busy}, 32'd0);
        idle(100);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 27, 1'b1, -1, 1'b0);
        check_rx("post_brk_5a");
        do_ack("post_brk_5a");

        exp_q.push_back(8'h11);
        send_frame(8'h11, 27, 1'b1, -1, 1'b0);
        check_rx("ovr_11");
        chk("ovr_first", {31'd0, u_bus.overrun}, 32'd0);
        exp_q.push_back(8'h22);
        send_frame(8'h22, 27, 1'b1, -1, 1'b0);
        check_rx("ovr_22");
        chk("ovr_set", {31'd0, u_bus.overrun}, 32'd1);
        do_ack("ovr_22");

        rx = 1'b0;
        idle(432);
        for (int i = 0; i < 4; i++) begin
            rx = (i == 3) ? 1'b0 : 1'b1;
            idle(432);
        end
        rst = 1'b1;
        rx = 1'b1;
        idle(1);
        chk("midrst_outs", {19'd0, u_bus.data_out, u_bus.data_valid,
            u_bus.frame_err, u_bus.overrun, u_bus.rx_busy}, 32'd0);
        idle(2);
        rst = 1'b0;
        idle(6 * 432);
        chk("midrst_novalid", {31'd0, u_bus.data_valid}, 32'd0);
        exp_q.push_back(8'h99);
        send_frame(8'h99, 27, 1'b1, -1, 1'b0);
        check_rx("post_rst_99");
        do_ack("post_rst_99");

        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 27, 1'b1, 3, 1'b1);
        check_rx("noise_ff");
        do_ack("noise_ff");
        baud_fix = 2'd3;

        idle(20);
        chk("sb_drained", exp_q.size(), 32'd0);
        chk("ferr_total", fe_hi - fe0, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
